sobel_window_reader: RTL
========================

// Module: sobel_window_reader
// PURPOSE
//  Read side of the 100->200 MHz pixel async FIFO. Pops 8-bit raster pixels in the 200 MHz domain,
//  keeps two line buffers plus a 3x3 shift window, and presents each interior 3x3 neighbourhood to the
//  Sobel core over a valid/ready handshake. The FIFO is a standard-mode FIFO: dout is valid 1 cycle after rd_en.
// PARAMETERS
//  IMG_WIDTH   64   pixels per row; must be >= 3
//  IMG_HEIGHT  128  rows per frame; must be >= 3 (64x128 = 8192 = BRAM depth)
//  PIX_W       8    pixel width in bits
// PORTS
//  clk_200mhz   in   1            sole clock, rising edge
//  reset_n      in   1            asynchronous active-low reset
//  start        in   1            1-cycle pulse, arms one frame (ignored unless IDLE)
//  fifo_dout    in   PIX_W        async FIFO read data
//  fifo_empty   in   1            async FIFO empty
//  rd_rst_busy  in   1            async FIFO read-side reset in progress
//  fifo_rd_en   out  1            FIFO pop strobe
//  win_data     out  9*PIX_W      3x3 window, [8*PIX_W+:PIX_W]=top-left ... [0+:PIX_W]=bottom-right, row-major
//  win_x        out  $clog2(IMG_WIDTH)   column of window centre
//  win_y        out  $clog2(IMG_HEIGHT)  row of window centre
//  win_valid    out  1            win_* hold a valid window
//  win_ready    in   1            Sobel core accepts window when win_valid&&win_ready
//  busy         out  1            high in STREAM/DRAIN
//  frame_done   out  1            1-cycle pulse after final pixel of the frame is consumed
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; counters, skid buffer and in-flight flag cleared. Line buffers unreset.
//  FSM: IDLE -start-> STREAM; STREAM -(IMG_WIDTH*IMG_HEIGHT pops issued)-> DRAIN;
//       DRAIN -(last pixel consumed and no window pending)-> DONE; DONE -> IDLE (frame_done=1 in DONE only).
//  Pop rule: fifo_rd_en = STREAM && !fifo_empty && !rd_rst_busy && pops<W*H && (skid_cnt+inflight-consume)<2.
//   inflight register = fifo_rd_en delayed 1 cycle; on inflight, fifo_dout is written into a 2-entry skid buffer.
//   Never pop while rd_rst_busy=1 or fifo_empty=1; a pop is never lost or duplicated.
//  Consume rule: one pixel taken from skid head per cycle when skid non-empty && (!win_valid || win_ready).
//   Arrival and consume in the same cycle are legal; sustained throughput is 1 pixel/cycle with win_ready=1.
//  Per consumed pixel P at (r,c): window columns shift left; new right column = {lb1[c], lb0[c], P};
//   lb1[c]<=lb0[c]; lb0[c]<=P; c increments, wraps to 0 at IMG_WIDTH-1 with r++.
//   At c==0 the window columns are logically cleared so no window spans a row boundary.
//  Window emit: if r>=2 && c>=2, on the next cycle win_valid=1, win_x=c-1, win_y=r-1.
//   Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame, in raster order of centre.
//  win_valid stays high and win_* stay stable until win_valid&&win_ready; then win_valid drops unless a new window
//   is produced that same cycle.
//  start while busy: ignored. rd_rst_busy mid-frame: popping pauses, state and counters hold.
//  reset_n low mid-frame: immediate return to IDLE with outputs 0; partial frame discarded.
// TESTING (bench params IMG_WIDTH=4, IMG_HEIGHT=4; pixel k = k)
//  reset, start, FIFO preloaded 0..15, win_ready=1 -> 4 windows; first win_x=1,win_y=1, data 0,1,2,4,5,6,8,9,10;
//   last win_x=2,win_y=2, data 5,6,7,9,10,11,13,14,15; one frame_done pulse; exactly 16 rd_en.
//  win_ready=0 for 20 cycles at first window -> win_data held stable; fifo_rd_en stops after skid fills (<=2 pops ahead).
//  fifo_empty toggled every other cycle -> same 4 windows, same order, no rd_en while empty.
//  rd_rst_busy=1 for 10 cycles after start -> fifo_rd_en=0 throughout; frame completes correctly afterwards.
//  start pulse during STREAM -> ignored, single frame_done; reset_n low after 7 pixels -> all outputs 0, next frame clean.
//  back-to-back frames (start after frame_done) -> second frame windows identical, no data from prior frame.

Source files
------------

// File: rtl/sobel_window_reader.sv
// -----------------------------------------------------------------------------
// sobel_window_reader
//
// Read side of the 100->200 MHz pixel async FIFO. Pops raster-order pixels,
// maintains two line buffers and a 3x3 shift window, and hands every interior
// 3x3 neighbourhood to the Sobel core over a valid/ready handshake.
//
// The FIFO is standard-mode: fifo_dout is valid one cycle after fifo_rd_en.
// Popped pixels land in a 2-entry skid buffer so a stall on win_ready never
// loses a pixel that is already in flight.
//
// Ports
//   clk_200mhz   in   sole clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   start        in   1-cycle pulse, arms one frame (only honoured in IDLE)
//   fifo_dout    in   FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_empty   in   FIFO empty
//   rd_rst_busy  in   FIFO read-side reset in progress
//   fifo_rd_en   out  FIFO pop strobe
//   win_data     out  3x3 window, row-major, top-left in the MSBs
//   win_x/win_y  out  column/row of the window centre
//   win_valid    out  win_* hold a valid window
//   win_ready    in   Sobel core accepts the window when win_valid && win_ready
//   busy         out  high while streaming or draining a frame
//   frame_done   out  1-cycle pulse once the whole frame has been consumed
// -----------------------------------------------------------------------------
module sobel_window_reader #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 128,
    parameter int PIX_W      = 8
) (
    input  logic                          clk_200mhz,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [PIX_W-1:0]              fifo_dout,
    input  logic                          fifo_empty,
    input  logic                          rd_rst_busy,
    output logic                          fifo_rd_en,
    output logic [9*PIX_W-1:0]            win_data,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic                          busy,
    output logic                          frame_done
);

    localparam int XW   = $clog2(IMG_WIDTH);
    localparam int YW   = $clog2(IMG_HEIGHT);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int PW   = $clog2(NPIX + 1);

    localparam logic [PW-1:0] NPIX_C  = PW'(NPIX);
    localparam logic [XW-1:0] LAST_X  = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] LAST_Y  = YW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Control state
    logic [PW-1:0]    pop_cnt;
    logic             inflight;
    logic [1:0]       skid_cnt;
    logic [PIX_W-1:0] skid0, skid1;
    logic [XW-1:0]    col_x;
    logic [YW-1:0]    row_y;
    logic             last_consumed;

    // Datapath state (unreset)
    logic [PIX_W-1:0] lb0 [IMG_WIDTH];
    logic [PIX_W-1:0] lb1 [IMG_WIDTH];
    logic [PIX_W-1:0] prev1_top, prev1_mid, prev1_bot;
    logic [PIX_W-1:0] prev2_top, prev2_mid, prev2_bot;

    logic             active;
    logic             consume;
    logic [2:0]       occ;
    logic             emit;
    logic [PIX_W-1:0] new_top, new_mid;
    logic [9*PIX_W-1:0] new_win;

    assign active  = (state_q == STREAM) || (state_q == DRAIN);
    assign consume = active && (skid_cnt != 2'd0) && (!win_valid || win_ready);

    // Skid occupancy once this cycle settles: pixels held + pixel arriving - pixel leaving.
    assign occ = {1'b0, skid_cnt} + {2'b00, inflight} - {2'b00, consume};

    assign emit = consume && (row_y >= YW'(2)) && (col_x >= XW'(2));

    assign new_top = lb1[col_x];
    assign new_mid = lb0[col_x];
    assign new_win = {prev2_top, prev1_top, new_top,
                      prev2_mid, prev1_mid, new_mid,
                      prev2_bot, prev1_bot, skid0};

    // ------------------------------------------------------------------
    // FSM next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fifo_rd_en = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = STREAM;
            end
            STREAM: begin
                busy       = 1'b1;
                fifo_rd_en = !fifo_empty && !rd_rst_busy &&
                             (pop_cnt < NPIX_C) && (occ < 3'd2);
                if (pop_cnt == NPIX_C) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (last_consumed && !win_valid) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Pop tracking, skid buffer, raster position
    // ------------------------------------------------------------------
    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            pop_cnt       <= '0;
            inflight      <= 1'b0;
            skid_cnt      <= 2'd0;
            skid0         <= '0;
            skid1         <= '0;
            col_x         <= '0;
            row_y         <= '0;
            last_consumed <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;

            if (state_q == IDLE && start) begin
                pop_cnt       <= '0;
                col_x         <= '0;
                row_y         <= '0;
                last_consumed <= 1'b0;
            end else begin
                if (fifo_rd_en) pop_cnt <= pop_cnt + PW'(1);
                if (consume) begin
                    if (col_x == LAST_X) begin
                        col_x <= '0;
                        row_y <= row_y + YW'(1);
                        if (row_y == LAST_Y) last_consumed <= 1'b1;
                    end else begin
                        col_x <= col_x + XW'(1);
                    end
                end
            end

            // skid0 is always the head; arrivals append behind whatever remains.
            case ({inflight, consume})
                2'b10: begin
                    if (skid_cnt == 2'd0) skid0 <= fifo_dout;
                    else                  skid1 <= fifo_dout;
                    skid_cnt <= skid_cnt + 2'd1;
                end
                2'b01: begin
                    skid0    <= skid1;
                    skid_cnt <= skid_cnt - 2'd1;
                end
                2'b11: begin
                    if (skid_cnt == 2'd1) begin
                        skid0 <= fifo_dout;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and window columns
    // ------------------------------------------------------------------
    always_ff @(posedge clk_200mhz) begin
        if (consume) begin
            lb1[col_x] <= lb0[col_x];
            lb0[col_x] <= skid0;
            // Starting a new row: drop the old columns so no window straddles rows.
            if (col_x == '0) begin
                prev2_top <= '0;
                prev2_mid <= '0;
                prev2_bot <= '0;
            end else begin
                prev2_top <= prev1_top;
                prev2_mid <= prev1_mid;
                prev2_bot <= prev1_bot;
            end
            prev1_top <= new_top;
            prev1_mid <= new_mid;
            prev1_bot <= skid0;
        end
    end

    // ------------------------------------------------------------------
    // Output window register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_200mhz or negedge reset_n) begin
        if (!reset_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
            win_x     <= '0;
            win_y     <= '0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= new_win;
            win_x     <= col_x - XW'(1);
            win_y     <= row_y - YW'(1);
        end else if (win_valid && win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule
